// File: rtl/pipe_ctrl.sv
// Central pipeline controller for the five-stage toy CPU.
// Merges ID, EX and MEM stall requests into one stall vector. It also
// sequences the multi-cycle EX divide and the exception freeze/flush redirect.
module pipe_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall_req,
    input  logic        ex_div_start,
    input  logic        mem_stall_req,
    input  logic        excp_req,
    input  logic [31:0] excp_vec,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        div_busy,
    output logic        div_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Stall vector encodings; bit5 is reserved and stays 0.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ALL  = 6'b011111;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        new_pc_q;

    logic               cnt_zero;
    logic               ex_div_stall;

    assign cnt_zero = (cnt_q == '0);

    // EX holds the pipe from the start cycle until the counter runs out.
    assign ex_div_stall = ((state_q == DIV) && !cnt_zero) ||
                          ((state_q == IDLE) && ex_div_start);

    // Prioritised stall/flush decode. Outputs are forced low while reset is
    // asserted so they drop asynchronously, even with requests active.
    always_comb begin
        stall = STALL_NONE;
        flush = 1'b0;
        if (rst) begin
            stall = STALL_NONE;
            flush = 1'b0;
        end else if (state_q == FLUSH) begin
            flush = 1'b1;
        end else if (excp_req) begin
            stall = STALL_ALL;
        end else if (mem_stall_req) begin
            stall = STALL_ALL;
        end else if (ex_div_stall) begin
            stall = STALL_EX;
        end else if (id_stall_req) begin
            stall = STALL_ID;
        end
    end

    // Divide status. An exception in the done cycle aborts the divide, so no
    // done pulse is produced then.
    always_comb begin
        div_busy = !rst && (state_q == DIV);
        div_done = !rst && (state_q == DIV) && cnt_zero && !excp_req;
    end

    assign new_pc = new_pc_q;

    // Control FSM: state, divide down-counter and the latched redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            new_pc_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (excp_req) begin
                        state_q  <= FLUSH;
                        new_pc_q <= excp_vec;
                    end else if (ex_div_start) begin
                        state_q <= DIV;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                DIV: begin
                    // The divider keeps counting through memory stalls.
                    if (excp_req) begin
                        state_q  <= FLUSH;
                        new_pc_q <= excp_vec;
                        cnt_q    <= '0;
                    end else if (cnt_zero) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                FLUSH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (DIV_CYCLES = 32).
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        id_stall_req;
    logic        ex_div_start;
    logic        mem_stall_req;
    logic        excp_req;
    logic [31:0] excp_vec;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        div_busy;
    logic        div_done;

    int checks;
    int errors;

    pipe_ctrl #(.DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_stall_req  (id_stall_req),
        .ex_div_start  (ex_div_start),
        .mem_stall_req (mem_stall_req),
        .excp_req      (excp_req),
        .excp_vec      (excp_vec),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .div_busy      (div_busy),
        .div_done      (div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check all status outputs at once.
    task automatic chk_out(input string tag, input logic [5:0] e_stall, input logic e_flush,
                           input logic e_busy, input logic e_done);
        chk({tag, ".stall"}, {26'd0, stall}, {26'd0, e_stall});
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
        chk({tag, ".busy"},  {31'd0, div_busy}, {31'd0, e_busy});
        chk({tag, ".done"},  {31'd0, div_done}, {31'd0, e_done});
    endtask

    // Move 1 time unit past the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive the inputs, then advance to mid-cycle for sampling.
    task automatic drive(input logic id, input logic st, input logic mem,
                         input logic ex, input logic [31:0] vec);
        id_stall_req  = id;
        ex_div_start  = st;
        mem_stall_req = mem;
        excp_req      = ex;
        excp_vec      = vec;
        #3;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        id_stall_req = 1'b0; ex_div_start = 1'b0; mem_stall_req = 1'b0;
        excp_req = 1'b0; excp_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 6'b000000, 1'b0, 1'b0, 1'b0);
        chk("reset.new_pc", new_pc, 32'h0);
        rst = 1'b0;

        // Asynchronous reset: enter FLUSH with all inputs high, then reset mid-cycle.
        next_cycle();
        drive(1, 1, 1, 1, 32'hDEAD_BEEF);
        chk_out("allhi", 6'b011111, 1'b0, 1'b0, 1'b0);
        next_cycle();
        chk_out("allhi_flush", 6'b000000, 1'b1, 1'b0, 1'b0);
        chk("allhi_flush.new_pc", new_pc, 32'hDEAD_BEEF);
        #2 rst = 1'b1;
        #1;
        chk_out("async_rst", 6'b000000, 1'b0, 1'b0, 1'b0);
        chk("async_rst.new_pc", new_pc, 32'h0);
        next_cycle();
        drive(0, 0, 0, 0, 32'h0);
        rst = 1'b0;
        next_cycle();
        drive(0, 0, 0, 0, 32'h0);
        chk_out("idle", 6'b000000, 1'b0, 1'b0, 1'b0);

        // Load-use stall, then mem stall outranks it.
        next_cycle(); drive(1, 0, 0, 0, 32'h0);
        chk_out("loaduse", 6'b000111, 1'b0, 1'b0, 1'b0);
        next_cycle(); drive(0, 0, 0, 0, 32'h0);
        chk_out("loaduse_end", 6'b000000, 1'b0, 1'b0, 1'b0);
        next_cycle(); drive(1, 0, 1, 0, 32'h0);
        chk_out("loaduse_mem", 6'b011111, 1'b0, 1'b0, 1'b0);
        next_cycle(); drive(0, 0, 0, 0, 32'h0);
        chk_out("mem_end", 6'b000000, 1'b0, 1'b0, 1'b0);

        // Plain divide; a second start at T+5 is ignored.
        next_cycle(); drive(0, 1, 0, 0, 32'h0);
        chk_out("div_T", 6'b001111, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 33; i++) begin
            next_cycle();
            drive(0, (i == 5), 0, 0, 32'h0);
            if (i <= 31)
                chk_out($sformatf("div_T+%0d", i), 6'b001111, 1'b0, 1'b1, 1'b0);
            else if (i == 32)
                chk_out("div_T+32", 6'b000000, 1'b0, 1'b1, 1'b1);
            else
                chk_out("div_T+33", 6'b000000, 1'b0, 1'b0, 1'b0);
        end

        // Divide under a memory stall covering T+10..T+40.
        next_cycle(); drive(0, 1, 0, 0, 32'h0);
        chk_out("dmem_T", 6'b001111, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 41; i++) begin
            logic       m;
            logic [5:0] es;
            m = (i >= 10) && (i <= 40);
            next_cycle();
            drive(0, 0, m, 0, 32'h0);
            es = m ? 6'b011111 : ((i <= 31) ? 6'b001111 : 6'b000000);
            chk_out($sformatf("dmem_T+%0d", i), es, 1'b0, (i <= 32), (i == 32));
        end

        // Exception during a divide at T+7; stall requests ignored during FLUSH.
        next_cycle(); drive(0, 1, 0, 0, 32'h0);
        chk_out("dexc_T", 6'b001111, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            next_cycle();
            if (i < 7) begin
                drive(0, 0, 0, 0, 32'h0);
                chk_out($sformatf("dexc_T+%0d", i), 6'b001111, 1'b0, 1'b1, 1'b0);
            end else if (i == 7) begin
                drive(0, 0, 0, 1, 32'h0000_0180);
                chk_out("dexc_T+7", 6'b011111, 1'b0, 1'b1, 1'b0);
            end else if (i == 8) begin
                drive(1, 1, 1, 1, 32'h0000_0999);
                chk_out("dexc_T+8", 6'b000000, 1'b1, 1'b0, 1'b0);
                chk("dexc_T+8.new_pc", new_pc, 32'h0000_0180);
            end else begin
                drive(0, 0, 0, 0, 32'h0);
                chk_out($sformatf("dexc_T+%0d", i), 6'b000000, 1'b0, 1'b0, 1'b0);
            end
        end

        // Back-to-back exceptions.
        next_cycle(); drive(0, 0, 0, 1, 32'h0000_0200);
        chk_out("bb_N", 6'b011111, 1'b0, 1'b0, 1'b0);
        next_cycle(); drive(0, 0, 0, 1, 32'h0000_0300);
        chk_out("bb_N+1", 6'b000000, 1'b1, 1'b0, 1'b0);
        chk("bb_N+1.new_pc", new_pc, 32'h0000_0200);
        next_cycle(); drive(0, 0, 0, 1, 32'h0000_0400);
        chk_out("bb_N+2", 6'b011111, 1'b0, 1'b0, 1'b0);
        next_cycle(); drive(0, 0, 0, 0, 32'h0);
        chk_out("bb_N+3", 6'b000000, 1'b1, 1'b0, 1'b0);
        chk("bb_N+3.new_pc", new_pc, 32'h0000_0400);
        next_cycle(); drive(0, 0, 0, 0, 32'h0);
        chk_out("bb_N+4", 6'b000000, 1'b0, 1'b0, 1'b0);

        // Reset mid-divide aborts without a done pulse.
        next_cycle(); drive(0, 1, 0, 0, 32'h0);
        next_cycle(); drive(0, 0, 0, 0, 32'h0);
        chk_out("rdiv_busy", 6'b001111, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk_out("rdiv_rst", 6'b000000, 1'b0, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 35; i++) begin
            next_cycle(); drive(0, 0, 0, 0, 32'h0);
            chk_out($sformatf("rdiv_after%0d", i), 6'b000000, 1'b0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
